float_add_pipe: RTL

FLOAT_ADD_PIPE -- requirements
Module: float_add_pipe

---
 rtl/float_add_pipe_if.sv | 33 +++
 rtl/float_add_pipe.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/float_add_pipe_if.sv
// float_add_pipe_if
//   Groups the operand handshake and result handshake of float_add_pipe.
//   Signals:
//     in_valid / in_ready : operand handshake (transfer when both high)
//     a, b, sub           : operands and add/subtract select
//     out_valid/out_ready : result handshake
//     out, overflow       : result word and saturation flag
//   Modports:
//     master : producer of operands and consumer of results (e.g. a bench)
//     slave  : the adder itself
interface float_add_pipe_if #(
  parameter int float_width = 32
);
  logic                   in_valid;
  logic                   in_ready;
  logic [float_width-1:0] a;
  logic [float_width-1:0] b;
  logic                   sub;
  logic                   out_valid;
  logic                   out_ready;
  logic [float_width-1:0] out;
  logic                   overflow;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, out, overflow
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, out, overflow
  );
endinterface

// File: rtl/float_add_pipe.sv
// float_add_pipe
//   Three-stage pipelined floating-point adder/subtractor with truncation.
//     S1: unpack, order by magnitude, align the smaller mantissa
//     S2: add or subtract magnitudes
//     S3: normalise, detect overflow/underflow, pack
//   Zero exponent means zero (no denormals); inf/NaN inputs are not special.
//   The whole pipeline stalls together when the result is held.
//   Ports:
//     clk : rising-edge clock
//     rst : synchronous active-high reset, drops everything in flight
//     bus : float_add_pipe_if.slave (operand and result handshakes)
module float_add_pipe #(
  parameter int float_width      = 32,
  parameter int float_exp_width  = 8,
  parameter int float_mant_width = 23
) (
  input  logic           clk,
  input  logic           rst,
  float_add_pipe_if.slave bus
);
  localparam int FW  = float_width;
  localparam int EW  = float_exp_width;
  localparam int MW  = float_mant_width;
  localparam int DW  = MW + 2;            // carry bit + hidden bit + fraction
  localparam int XW  = EW + 2;            // exponent with headroom and sign
  localparam int LZW = $clog2(DW + 1);
  localparam logic [31:0]   SHIFT_LIM = 32'(MW + 2);
  localparam logic [XW-1:0] EXP_MAX   = {2'b00, {EW{1'b1}}};

  // Global stall: every stage moves only when the output slot frees up.
  logic advance;
  assign advance      = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = advance;

  // ---------------- S1: unpack / compare / align ----------------
  logic [FW-1:0] op_raw  [2];
  logic          op_sign [2];
  logic [EW-1:0] op_exp  [2];
  logic [MW:0]   op_man  [2];

  assign op_raw[0] = bus.a;
  assign op_raw[1] = bus.b;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_unpack
      assign op_exp[gi]  = op_raw[gi][MW +: EW];
      // A zero exponent forces the whole magnitude to zero, fraction ignored.
      assign op_man[gi]  = (op_exp[gi] != '0) ? {1'b1, op_raw[gi][MW-1:0]} : '0;
      // Only operand b is affected by the subtract select.
      assign op_sign[gi] = op_raw[gi][FW-1] ^ (bus.sub & (gi == 1));
    end
  endgenerate

  logic          a_ge_b;
  logic          s1_sign_next;
  logic          s1_eff_sub_next;
  logic [EW-1:0] s1_exp_next;
  logic [EW-1:0] exp_small;
  logic [EW-1:0] exp_diff;
  logic [MW:0]   s1_man_l_next;
  logic [MW:0]   man_small;
  logic [MW:0]   s1_man_s_next;

  assign a_ge_b = {op_exp[0], op_man[0]} >= {op_exp[1], op_man[1]};

  always_comb begin
    s1_sign_next    = a_ge_b ? op_sign[0] : op_sign[1];
    s1_exp_next     = a_ge_b ? op_exp[0]  : op_exp[1];
    s1_man_l_next   = a_ge_b ? op_man[0]  : op_man[1];
    exp_small       = a_ge_b ? op_exp[1]  : op_exp[0];
    man_small       = a_ge_b ? op_man[1]  : op_man[0];
    s1_eff_sub_next = op_sign[0] ^ op_sign[1];
    exp_diff        = s1_exp_next - exp_small;
    if (32'(exp_diff) >= SHIFT_LIM) begin
      s1_man_s_next = '0;
    end else begin
      s1_man_s_next = man_small >> exp_diff;
    end
  end

  logic          s1_valid_reg;
  logic          s1_sign_reg;
  logic          s1_eff_sub_reg;
  logic [EW-1:0] s1_exp_reg;
  logic [MW:0]   s1_man_l_reg;
  logic [MW:0]   s1_man_s_reg;

  // ---------------- S2: magnitude add / subtract ----------------
  logic [DW-1:0] s2_sum_next;
  assign s2_sum_next = s1_eff_sub_reg ? ({1'b0, s1_man_l_reg} - {1'b0, s1_man_s_reg})
                                      : ({1'b0, s1_man_l_reg} + {1'b0, s1_man_s_reg});

  logic          s2_valid_reg;
  logic          s2_sign_reg;
  logic [EW-1:0] s2_exp_reg;
  logic [DW-1:0] s2_sum_reg;

  // ---------------- S3: normalise / pack ----------------
  logic [LZW-1:0] lz;
  logic           lz_found;
  logic [MW-1:0]  norm_frac;
  logic [XW-1:0]  norm_exp;
  logic [FW-1:0]  res_next;
  logic           ovf_next;

  always_comb begin
    lz       = '0;
    lz_found = 1'b0;
    // Leading zeros below the carry bit; only meaningful without carry.
    for (int i = DW - 2; i >= 0; i--) begin
      if (!lz_found) begin
        if (s2_sum_reg[i]) lz_found = 1'b1;
        else               lz = lz + LZW'(1);
      end
    end
  end

  always_comb begin
    norm_frac = '0;
    norm_exp  = '0;
    res_next  = '0;
    ovf_next  = 1'b0;
    if (s2_sum_reg[DW-1]) begin
      norm_frac = s2_sum_reg[MW:1];
      norm_exp  = {2'b00, s2_exp_reg} + XW'(1);
    end else begin
      // The hidden bit lands just above the stored fraction and drops off.
      norm_frac = s2_sum_reg[MW-1:0] << lz;
      norm_exp  = {2'b00, s2_exp_reg} - XW'(lz);
    end
    if (s2_sum_reg == '0) begin
      res_next = '0;                          // exact cancellation or 0+0
    end else if (norm_exp[XW-1] || norm_exp == '0) begin
      res_next = '0;                          // underflow flushes to +0
    end else if (norm_exp >= EXP_MAX) begin
      res_next = {s2_sign_reg, {EW{1'b1}}, {MW{1'b0}}};
      ovf_next = 1'b1;
    end else begin
      res_next = {s2_sign_reg, norm_exp[EW-1:0], norm_frac};
    end
  end

  logic          out_valid_reg;
  logic [FW-1:0] out_reg;
  logic          overflow_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg   <= 1'b0;
      s1_sign_reg    <= 1'b0;
      s1_eff_sub_reg <= 1'b0;
      s1_exp_reg     <= '0;
      s1_man_l_reg   <= '0;
      s1_man_s_reg   <= '0;
      s2_valid_reg   <= 1'b0;
      s2_sign_reg    <= 1'b0;
      s2_exp_reg     <= '0;
      s2_sum_reg     <= '0;
      out_valid_reg  <= 1'b0;
      out_reg        <= '0;
      overflow_reg   <= 1'b0;
    end else if (advance) begin
      s1_valid_reg  <= bus.in_valid;
      s2_valid_reg  <= s1_valid_reg;
      out_valid_reg <= s2_valid_reg;
      if (bus.in_valid) begin
        s1_sign_reg    <= s1_sign_next;
        s1_eff_sub_reg <= s1_eff_sub_next;
        s1_exp_reg     <= s1_exp_next;
        s1_man_l_reg   <= s1_man_l_next;
        s1_man_s_reg   <= s1_man_s_next;
      end
      if (s1_valid_reg) begin
        s2_sign_reg <= s1_sign_reg;
        s2_exp_reg  <= s1_exp_reg;
        s2_sum_reg  <= s2_sum_next;
      end
      if (s2_valid_reg) begin
        out_reg      <= res_next;
        overflow_reg <= ovf_next;
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out       = out_reg;
  assign bus.overflow  = overflow_reg;
endmodule
